// File: rtl/wptr_full.sv
// Write-domain pointer and full-flag generator for the dual-clock FIFO.
// Holds the binary write counter, publishes its Gray image to the read
// domain, and derives full / almost-full / level / overflow status from
// the synchronized Gray read pointer. Status is pessimistic because the
// read pointer it sees is always stale.
module wptr_full #(
  parameter int ASIZE    = 4,
  parameter int AF_LEVEL = 12
) (
  input  logic             wclk,
  input  logic             wrst_n,
  input  logic             winc,
  input  logic [ASIZE:0]   wq2_rptr,
  input  logic             wovf_clr,
  output logic [ASIZE-1:0] waddr,
  output logic [ASIZE:0]   wptr,
  output logic             wfull,
  output logic             walmost_full,
  output logic [ASIZE:0]   wlevel,
  output logic             wovf
);

  localparam logic [ASIZE:0] AF_THR = (ASIZE+1)'(AF_LEVEL);

  // Gray to binary: each binary bit is the XOR of all Gray bits at or above it.
  function automatic logic [ASIZE:0] gray2bin(input logic [ASIZE:0] g);
    logic [ASIZE:0] b;
    b[ASIZE] = g[ASIZE];
    for (int i = ASIZE - 1; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  logic [ASIZE:0] wbin;
  logic [ASIZE:0] wbin_next;
  logic [ASIZE:0] wgray_next;
  logic [ASIZE:0] rbin_s;
  logic [ASIZE:0] lvl_next;
  logic [ASIZE:0] full_cmp;
  logic           push;

  // Next-pointer, level and full-compare arithmetic for this cycle.
  always_comb begin
    push       = winc & ~wfull;
    wbin_next  = wbin + {{ASIZE{1'b0}}, push};
    wgray_next = (wbin_next >> 1) ^ wbin_next;
    rbin_s     = gray2bin(wq2_rptr);
    // Modulo subtraction: the extra MSB keeps the difference in 0..2**ASIZE.
    lvl_next   = wbin_next - rbin_s;
    // Full when the write pointer is one lap ahead: top two Gray bits
    // inverted, the rest equal.
    full_cmp   = {~wq2_rptr[ASIZE:ASIZE-1], wq2_rptr[ASIZE-2:0]};
  end

  // The RAM address is the low bits of the binary counter, straight off a flop.
  assign waddr = wbin[ASIZE-1:0];

  // Pointer and status registers. wptr is a flop output with no logic after
  // it, so it is safe to send across the clock boundary.
  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      wbin         <= '0;
      wptr         <= '0;
      wfull        <= 1'b0;
      walmost_full <= 1'b0;
      wlevel       <= '0;
    end else begin
      wbin         <= wbin_next;
      wptr         <= wgray_next;
      wfull        <= (wgray_next == full_cmp);
      walmost_full <= (lvl_next >= AF_THR);
      wlevel       <= lvl_next;
    end
  end

  // Sticky overflow: a write attempted while full sets it, and the set wins
  // over a clear in the same cycle so no event is lost.
  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n)
      wovf <= 1'b0;
    else if (winc & wfull)
      wovf <= 1'b1;
    else if (wovf_clr)
      wovf <= 1'b0;
  end

endmodule

// File: tb/tb_wptr_full.sv
// Directed bench for wptr_full (ASIZE=4, AF_LEVEL=12).
module tb_wptr_full;

  logic       wclk;
  logic       wrst_n;
  logic       winc;
  logic [4:0] wq2_rptr;
  logic       wovf_clr;
  logic [3:0] waddr;
  logic [4:0] wptr;
  logic       wfull;
  logic       walmost_full;
  logic [4:0] wlevel;
  logic       wovf;

  int nvec = 0;
  int nerr = 0;

  wptr_full #(.ASIZE(4), .AF_LEVEL(12)) dut (
    .wclk         (wclk),
    .wrst_n       (wrst_n),
    .winc         (winc),
    .wq2_rptr     (wq2_rptr),
    .wovf_clr     (wovf_clr),
    .waddr        (waddr),
    .wptr         (wptr),
    .wfull        (wfull),
    .walmost_full (walmost_full),
    .wlevel       (wlevel),
    .wovf         (wovf)
  );

  initial wclk = 1'b0;
  always #5 wclk = ~wclk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    if (obs !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [4:0] gry(input int b);
    logic [4:0] v;
    v = 5'(b);
    return v ^ (v >> 1);
  endfunction

  task automatic tick();
    @(posedge wclk);
    #1;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_waddr"}, 32'(waddr), 32'd0);
    chk({tag, "_wptr"},  32'(wptr),  32'd0);
    chk({tag, "_wfull"}, 32'(wfull), 32'd0);
    chk({tag, "_waf"},   32'(walmost_full), 32'd0);
    chk({tag, "_wlvl"},  32'(wlevel), 32'd0);
    chk({tag, "_wovf"},  32'(wovf),  32'd0);
  endtask

  task automatic do_reset();
    winc     = 1'b0;
    wovf_clr = 1'b0;
    wq2_rptr = 5'd0;
    wrst_n   = 1'b0;
    #3;
    @(negedge wclk);
    wrst_n = 1'b1;
  endtask

  initial begin
    logic [4:0] prev;
    int b;

    // reset state and asynchronous mid-stream reset
    do_reset();
    chk_zero("rst");
    winc = 1'b1;
    repeat (5) tick();
    chk("pre_rst_addr", 32'(waddr), 32'd5);
    chk("pre_rst_ptr",  32'(wptr),  32'(gry(5)));
    #2 wrst_n = 1'b0;
    #1;
    chk_zero("async");
    winc = 1'b0;
    @(negedge wclk);
    wrst_n = 1'b1;
    winc = 1'b1;
    #1;
    chk("post_rst_addr0", 32'(waddr), 32'd0);
    tick();
    chk("post_rst_wptr", 32'(wptr), 32'h01);
    chk("post_rst_addr1", 32'(waddr), 32'd1);
    winc = 1'b0;

    // fill 16 entries with the reader idle
    do_reset();
    winc = 1'b1;
    for (int i = 0; i < 16; i++) begin
      chk("fill_addr", 32'(waddr), 32'(i));
      tick();
      chk("fill_wptr", 32'(wptr), 32'(gry(i + 1)));
      chk("fill_lvl",  32'(wlevel), 32'(i + 1));
      chk("fill_af",   32'(walmost_full), (i + 1 >= 12) ? 32'd1 : 32'd0);
      chk("fill_full", 32'(wfull), (i + 1 == 16) ? 32'd1 : 32'd0);
    end

    // overflow while full
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("ovf_wptr", 32'(wptr),  32'h18);
      chk("ovf_flag", 32'(wovf),  32'd1);
      chk("ovf_full", 32'(wfull), 32'd1);
      chk("ovf_lvl",  32'(wlevel), 32'd16);
    end
    wovf_clr = 1'b1;
    tick();
    chk("ovf_set_wins", 32'(wovf), 32'd1);
    winc = 1'b0;
    tick();
    chk("ovf_clr", 32'(wovf), 32'd0);
    wovf_clr = 1'b0;

    // drain release: one pop becomes visible
    wq2_rptr = 5'b00001;
    tick();
    chk("drain_full", 32'(wfull),  32'd0);
    chk("drain_lvl",  32'(wlevel), 32'd15);
    chk("drain_af",   32'(walmost_full), 32'd1);
    chk("drain_wptr", 32'(wptr),   32'h18);
    winc = 1'b1;
    #1;
    chk("drain_addr", 32'(waddr), 32'd0);
    tick();
    chk("drain_wptr2", 32'(wptr),   32'h19);
    chk("drain_lvl2",  32'(wlevel), 32'd16);
    chk("drain_full2", 32'(wfull),  32'd1);
    winc = 1'b0;

    // wrap with the reader trailing by 3
    do_reset();
    winc = 1'b1;
    repeat (3) tick();
    b = 3;
    chk("wrap_lvl0", 32'(wlevel), 32'd3);
    for (int k = 0; k < 40; k++) begin
      prev = wptr;
      wq2_rptr = gry(b + 1 - 3);
      tick();
      b++;
      chk("wrap_lvl",  32'(wlevel), 32'd3);
      chk("wrap_full", 32'(wfull),  32'd0);
      chk("wrap_1bit", 32'($countones(wptr ^ prev)), 32'd1);
      chk("wrap_wptr", 32'(wptr), 32'(gry(b)));
      chk("wrap_addr", 32'(waddr), 32'(b % 16));
    end
    winc = 1'b0;

    // almost-full threshold
    do_reset();
    winc = 1'b1;
    repeat (11) tick();
    chk("thr_lvl11", 32'(wlevel), 32'd11);
    chk("thr_af0",   32'(walmost_full), 32'd0);
    wq2_rptr = gry(1);
    tick();
    chk("thr_pushpop_lvl", 32'(wlevel), 32'd11);
    chk("thr_pushpop_af",  32'(walmost_full), 32'd0);
    tick();
    chk("thr_push_lvl", 32'(wlevel), 32'd12);
    chk("thr_push_af",  32'(walmost_full), 32'd1);
    winc = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
